// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the multi-cycle stage sequencer: status codes,
// instruction codes, FSM state encoding and the memory-instruction classifier.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } state_t;

  function automatic logic is_mem_icode(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IMRMOVQ) || (icode == ICALL) ||
           (icode == IRET)    || (icode == IPUSHQ)  || (icode == IPOPQ);
  endfunction

endpackage

// File: rtl/y86_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEMORY handshakes; flags the
// last permitted un-acknowledged cycle so the FSM can fault on it.
module y86_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Expired during the MEM_TIMEOUT-th waiting cycle, so the request is
  // visible for exactly MEM_TIMEOUT cycles before the fault takes effect.
  assign o_expired = i_count && (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_count && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/y86_mc_ctrl.sv
// Multi-cycle stage sequencer: steps fetch/decode/execute/memory/writeback/
// PC update in order, handshakes with both memories and tracks Y86 status.
module y86_mc_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned             ADDR_W      = 64,
  parameter int unsigned             CNT_W       = 32,
  parameter int                      MEM_TIMEOUT = 16,
  parameter logic [ADDR_W-1:0]       RESET_PC    = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_step_mode,
  input  logic [3:0]        i_icode,
  input  logic              i_instr_valid,
  input  logic              i_imem_ack,
  input  logic              i_imem_error,
  input  logic              i_dmem_ack,
  input  logic              i_dmem_error,
  input  logic [ADDR_W-1:0] i_next_pc,
  output logic              o_imem_req,
  output logic              o_dmem_req,
  output logic              o_dec_en,
  output logic              o_exe_en,
  output logic              o_wb_en,
  output logic [ADDR_W-1:0] o_pc,
  output logic [2:0]        o_stat,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [CNT_W-1:0]  o_instr_count
);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_stat, w_stat_next;
  logic [CNT_W-1:0]  r_cycle_count, r_instr_count;
  logic              w_retire, w_pc_load;
  logic              w_wait_clear, w_wait_count, w_expired;

  assign w_wait_clear = (r_state != S_FETCH) && (r_state != S_MEMORY);
  assign w_wait_count = ((r_state == S_FETCH)  && !i_imem_ack) ||
                        ((r_state == S_MEMORY) && !i_dmem_ack);

  y86_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_wait_clear),
    .i_count   (w_wait_count),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    w_stat_next  = r_stat;
    w_retire     = 1'b0;
    w_pc_load    = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = S_FETCH;
      S_FETCH: begin
        if (i_imem_ack) begin
          if (i_imem_error) begin
            w_stat_next  = STAT_ADR;
            w_state_next = S_HALT;
          end else if (!i_instr_valid) begin
            w_stat_next  = STAT_INS;
            w_state_next = S_HALT;
          end else if (i_icode == IHALT) begin
            w_stat_next  = STAT_HLT;
            w_retire     = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_state_next = S_DECODE;
          end
        end else if (w_expired) begin
          w_stat_next  = STAT_ADR;
          w_state_next = S_HALT;
        end
      end
      S_DECODE:  w_state_next = S_EXECUTE;
      S_EXECUTE: w_state_next = is_mem_icode(i_icode) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (i_dmem_ack) begin
          if (i_dmem_error) begin
            w_stat_next  = STAT_ADR;
            w_state_next = S_HALT;
          end else begin
            w_state_next = S_WRITEBACK;
          end
        end else if (w_expired) begin
          w_stat_next  = STAT_ADR;
          w_state_next = S_HALT;
        end
      end
      S_WRITEBACK: w_state_next = S_PCUPD;
      S_PCUPD: begin
        w_pc_load    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = i_step_mode ? S_IDLE : S_FETCH;
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_stat        <= STAT_AOK;
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_stat  <= w_stat_next;
      if (w_pc_load) r_pc <= i_next_pc;
      if (w_retire && (r_instr_count != '1)) r_instr_count <= r_instr_count + 1'b1;
      if (o_busy && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + 1'b1;
    end
  end

  assign o_imem_req    = (r_state == S_FETCH);
  assign o_dmem_req    = (r_state == S_MEMORY);
  assign o_dec_en      = (r_state == S_DECODE);
  assign o_exe_en      = (r_state == S_EXECUTE);
  assign o_wb_en       = (r_state == S_WRITEBACK);
  assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_pc          = r_pc;
  assign o_stat        = r_stat;
  assign o_cycle_count = r_cycle_count;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_y86_mc_ctrl.sv
// Scoreboard bench for y86_mc_ctrl: bench-side memory responders, expected
// end-of-run state queued at launch and compared when the FSM settles.
module tb_y86_mc_ctrl;
  import y86_pkg::*;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_start = 1'b0, i_step_mode = 1'b1;
  logic [3:0]  i_icode = 4'h6;
  logic        i_instr_valid = 1'b1;
  logic        i_imem_ack = 1'b0, i_imem_error = 1'b0;
  logic        i_dmem_ack = 1'b0, i_dmem_error = 1'b0;
  logic [63:0] i_next_pc = 64'h0;
  logic        o_imem_req, o_dmem_req, o_dec_en, o_exe_en, o_wb_en, o_busy;
  logic [63:0] o_pc;
  logic [2:0]  o_stat;
  logic [31:0] o_cycle_count, o_instr_count;

  always #5 clk = ~clk;

  y86_mc_ctrl #(.ADDR_W(64), .CNT_W(32), .MEM_TIMEOUT(16), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_step_mode(i_step_mode),
    .i_icode(i_icode), .i_instr_valid(i_instr_valid),
    .i_imem_ack(i_imem_ack), .i_imem_error(i_imem_error),
    .i_dmem_ack(i_dmem_ack), .i_dmem_error(i_dmem_error), .i_next_pc(i_next_pc),
    .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_dec_en(o_dec_en),
    .o_exe_en(o_exe_en), .o_wb_en(o_wb_en), .o_pc(o_pc), .o_stat(o_stat),
    .o_busy(o_busy), .o_cycle_count(o_cycle_count), .o_instr_count(o_instr_count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    int          icnt;
    int          ccnt;
    int          busy;
  } exp_t;

  exp_t        sb_q[$];
  logic [3:0]  prog_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_busy, n_dec, n_exe, n_wb, n_imreq, n_dmreq, n_excl = 0, n_ovl = 0;
  int t_dec, t_exe, t_wb, t_dm_last;
  int im_wait = 0, dm_wait = 0, im_cnt = 0, dm_cnt = 0;
  logic im_err = 1'b0, dm_err = 1'b0;
  logic [63:0] exp_pc;
  logic [2:0]  exp_stat;
  int exp_icnt, exp_ccnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the falling edge, then drive the memory responses.
  task automatic tick();
    @(negedge clk);
    cyc++;
    n_busy += int'(o_busy);
    if (o_dec_en) begin n_dec++; t_dec = cyc; end
    if (o_exe_en) begin n_exe++; t_exe = cyc; end
    if (o_wb_en)  begin n_wb++;  t_wb  = cyc; end
    if (o_imem_req) n_imreq++;
    if (o_dmem_req) begin n_dmreq++; t_dm_last = cyc; end
    if (int'(o_dec_en) + int'(o_exe_en) + int'(o_wb_en) > 1) n_excl++;
    if (o_imem_req && o_dmem_req) n_ovl++;
    if (o_imem_req) begin
      i_imem_ack   = (im_cnt == im_wait);
      i_imem_error = i_imem_ack ? im_err : 1'b0;
      if (i_imem_ack && prog_q.size() > 0) i_icode = prog_q.pop_front();
      im_cnt++;
    end else begin
      i_imem_ack = 1'b0; i_imem_error = 1'b0; im_cnt = 0;
    end
    if (o_dmem_req) begin
      i_dmem_ack   = (dm_cnt == dm_wait);
      i_dmem_error = i_dmem_ack ? dm_err : 1'b0;
      dm_cnt++;
    end else begin
      i_dmem_ack = 1'b0; i_dmem_error = 1'b0; dm_cnt = 0;
    end
  endtask

  task automatic clear_stats();
    n_busy = 0; n_dec = 0; n_exe = 0; n_wb = 0; n_imreq = 0; n_dmreq = 0;
    t_dec = -100; t_exe = -100; t_wb = -100; t_dm_last = -100;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_start = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    exp_pc = RST_PC; exp_stat = STAT_AOK; exp_icnt = 0; exp_ccnt = 0;
  endtask

  task automatic push_exp(input int busy_cycles);
    exp_t e;
    e.pc = exp_pc; e.stat = exp_stat; e.icnt = exp_icnt; e.ccnt = exp_ccnt; e.busy = busy_cycles;
    sb_q.push_back(e);
  endtask

  task automatic run(input int budget);
    int k = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (o_busy && k < budget) begin
      tick();
      k++;
    end
    check("settled", 64'(o_busy), 64'd0);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    check({tag, "_pc"},   o_pc, e.pc);
    check({tag, "_stat"}, 64'(o_stat), 64'(e.stat));
    check({tag, "_icnt"}, 64'(o_instr_count), 64'(e.icnt));
    check({tag, "_ccnt"}, 64'(o_cycle_count), 64'(e.ccnt));
    check({tag, "_busy"}, 64'(n_busy), 64'(e.busy));
    $display("txn %s: pc=%0h stat=%0d icnt=%0d ccnt=%0d busy_cycles=%0d",
             tag, o_pc, o_stat, o_instr_count, o_cycle_count, n_busy);
  endtask

  initial begin
    clear_stats();
    do_reset();
    check("rst_pc", o_pc, RST_PC);
    check("rst_stat", 64'(o_stat), 64'(STAT_AOK));
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_icnt", 64'(o_instr_count), 64'd0);
    check("rst_ccnt", 64'(o_cycle_count), 64'd0);
    check("rst_req", 64'({o_imem_req, o_dmem_req, o_dec_en, o_exe_en, o_wb_en}), 64'd0);

    // OPq, zero-wait, single step
    i_step_mode = 1'b1; prog_q = '{4'h6}; i_next_pc = 64'h2; clear_stats();
    exp_pc = 64'h2; exp_icnt = 1; exp_ccnt = 5; push_exp(5);
    run(50); pop_check("opq");
    check("opq_dec", 64'(n_dec), 64'd1);
    check("opq_wb", 64'(n_wb), 64'd1);
    check("opq_dec_exe", 64'(t_exe - t_dec), 64'd1);
    check("opq_exe_wb", 64'(t_wb - t_exe), 64'd1);
    check("opq_dmreq", 64'(n_dmreq), 64'd0);

    // mrmovq, dmem ack after 3 wait cycles
    prog_q = '{4'h5}; dm_wait = 3; i_next_pc = 64'hc; clear_stats();
    exp_pc = 64'hc; exp_icnt = 2; exp_ccnt = 14; push_exp(9);
    run(50); pop_check("mrmov");
    check("mrmov_dmreq", 64'(n_dmreq), 64'd4);
    check("mrmov_wb_after_ack", 64'(t_wb - t_dm_last), 64'd1);
    check("mrmov_wb", 64'(n_wb), 64'd1);

    // pushq, ack on the last permitted cycle: ack beats expiry
    prog_q = '{4'hA}; dm_wait = 15; i_next_pc = 64'h20; clear_stats();
    exp_pc = 64'h20; exp_icnt = 3; exp_ccnt = 35; push_exp(21);
    run(100); pop_check("push_edge");
    check("push_edge_dmreq", 64'(n_dmreq), 64'd16);

    // free-running: OPq then halt, one-wait fetches
    i_step_mode = 1'b0; prog_q = '{4'h6, 4'h0}; im_wait = 1; dm_wait = 0;
    i_next_pc = 64'h30; clear_stats();
    exp_pc = 64'h30; exp_stat = STAT_HLT; exp_icnt = 5; exp_ccnt = 43; push_exp(8);
    run(100); pop_check("halt");
    clear_stats();
    for (int i = 0; i < 3; i++) begin
      i_start = 1'b1; tick(); i_start = 1'b0; tick();
    end
    check("halt_start_busy", 64'(n_busy), 64'd0);
    check("halt_hold_pc", o_pc, 64'h30);
    check("halt_hold_stat", 64'(o_stat), 64'(STAT_HLT));
    check("halt_hold_ccnt", 64'(o_cycle_count), 64'd43);

    // instruction memory never acknowledges
    do_reset(); i_step_mode = 1'b1; im_wait = 1000; prog_q = '{4'h6}; clear_stats();
    exp_stat = STAT_ADR; exp_ccnt = 16; push_exp(16);
    run(100); pop_check("ifetch_to");
    check("ifetch_to_imreq", 64'(n_imreq), 64'd16);
    check("ifetch_to_dec", 64'(n_dec), 64'd0);
    check("ifetch_to_req_now", 64'(o_imem_req), 64'd0);

    // imem_error outranks invalid instruction
    do_reset(); im_wait = 0; im_err = 1'b1; i_instr_valid = 1'b0; prog_q = '{4'h6}; clear_stats();
    exp_stat = STAT_ADR; exp_ccnt = 1; push_exp(1);
    run(20); pop_check("ifetch_err");
    im_err = 1'b0;

    // invalid instruction outranks halt icode
    do_reset(); prog_q = '{4'h0}; clear_stats();
    exp_stat = STAT_INS; exp_ccnt = 1; push_exp(1);
    run(20); pop_check("ins");
    i_instr_valid = 1'b1;

    // call with dmem error: no writeback, no PC update
    do_reset(); prog_q = '{4'h8}; dm_wait = 2; dm_err = 1'b1; i_next_pc = 64'h55; clear_stats();
    exp_stat = STAT_ADR; exp_ccnt = 6; push_exp(6);
    run(50); pop_check("dmem_err");
    check("dmem_err_wb", 64'(n_wb), 64'd0);
    dm_err = 1'b0; dm_wait = 0;

    // three single-stepped OPq instructions
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      prog_q = '{4'h6}; i_next_pc = 64'(i * 16); clear_stats();
      exp_pc = 64'(i * 16); exp_icnt = i; exp_ccnt = 5 * i; push_exp(5);
      run(50); pop_check($sformatf("step%0d", i));
    end

    // reset in the middle of a memory wait
    prog_q = '{4'h5}; dm_wait = 1000; clear_stats();
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 0; k < 20 && !o_dmem_req; k++) tick();
    tick(); tick();
    check("midrst_dmreq_before", 64'(o_dmem_req), 64'd1);
    i_reset = 1'b1; tick();
    check("midrst_dmreq", 64'(o_dmem_req), 64'd0);
    check("midrst_pc", o_pc, RST_PC);
    check("midrst_stat", 64'(o_stat), 64'(STAT_AOK));
    check("midrst_icnt", 64'(o_instr_count), 64'd0);
    check("midrst_ccnt", 64'(o_cycle_count), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_wb", 64'(n_wb), 64'd0);
    i_reset = 1'b0; tick();

    check("en_exclusive", 64'(n_excl), 64'd0);
    check("req_exclusive", 64'(n_ovl), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_mc_ctrl.md
Name: y86_mc_ctrl

Overview:
Multi-cycle stage sequencer for the Y86-64 core. It replaces free-running, clock-edge-coupled stages with an explicit FSM that enables fetch, decode, execute, memory, writeback and PC update in order. It handshakes with variable-latency instruction and data memories, and tracks architectural status (AOK/HLT/ADR/INS). It adds single-step mode, memory timeout detection, and cycle/instruction counters.

Parameters:
ADDR_W, 64, PC and next_pc width
CNT_W, 32, width of cycle_count and instr_count
MEM_TIMEOUT, 16, max wait cycles for imem/dmem ack before ADR fault (>=1)
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  begin or resume execution from IDLE
step_mode  in  1  1 = return to IDLE after each retired instruction
icode  in  4  decoded instruction code from fetch
instr_valid  in  1  fetch instruction-valid flag
imem_ack  in  1  instruction memory data valid
imem_error  in  1  instruction fetch address error, sampled with imem_ack
dmem_ack  in  1  data memory access complete
dmem_error  in  1  data memory address error, sampled with dmem_ack
next_pc  in  ADDR_W  PC computed by PC-update logic
imem_req  out  1  fetch request, held until ack or timeout
dmem_req  out  1  data memory request, held until ack or timeout
dec_en  out  1  decode/register-read enable, 1 cycle
exe_en  out  1  ALU/CC enable, 1 cycle
wb_en  out  1  register-file write enable, 1 cycle
pc  out  ADDR_W  current program counter
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
busy  out  1  FSM in any state other than IDLE/HALT
cycle_count  out  CNT_W  cycles spent busy, saturating
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset: state IDLE; pc=RESET_PC; stat=AOK; counters 0; all req/en outputs 0; busy 0. Reset during any state aborts immediately: requests drop in the cycle after reset is sampled and no register write or PC update occurs.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE -> FETCH when start=1; otherwise hold.
- FETCH: imem_req=1.
  - On imem_ack, checks run in priority order: imem_error -> stat=ADR, HALT; else instr_valid=0 -> stat=INS, HALT; else icode=0 -> stat=HLT, instr_count+1, HALT; else -> DECODE.
- DECODE: dec_en=1 for one cycle -> EXECUTE.
- EXECUTE: exe_en=1 for one cycle. Next state is MEMORY if icode is in {4,5,8,9,A,B}; otherwise WRITEBACK.
- MEMORY: dmem_req=1 until dmem_ack. On ack: dmem_error -> stat=ADR, HALT with no writeback and no PC update; else -> WRITEBACK.
- WRITEBACK: wb_en=1 for one cycle -> PCUPD.
- PCUPD: pc<=next_pc; instr_count+1. Next state is IDLE if step_mode=1, else FETCH.
- Timeout: a wait counter clears on entry to FETCH/MEMORY and increments each cycle without ack. When it reaches MEM_TIMEOUT: stat=ADR, HALT, request dropped. If ack and expiry occur in the same cycle, ack wins.
- HALT: terminal, held until reset; start ignored; stat frozen; pc holds address of the faulting/halt instruction.
- start while busy is ignored. step_mode is sampled only in PCUPD.
- cycle_count increments every cycle busy=1. Both counters saturate at all-ones without wrapping.
- Latency with zero-wait acks (ack in first req cycle): non-memory instruction 5 cycles FETCH->PCUPD inclusive; memory instruction 6 cycles.
- At most one of dec_en/exe_en/wb_en is high in any cycle. imem_req and dmem_req are never high together.

Decomposition:
- Shared package y86_pkg: stat codes (STAT_AOK..STAT_INS), icode constants (IHALT, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ), FSM state encoding, helper function is_mem_icode.
- One sub-module: y86_wait_timer (clear, count, expired flag, parameter MEM_TIMEOUT), instantiated once and shared by FETCH and MEMORY.

Test Plan:
1. Reset, start=1, icode=6 (OPq), acks immediate, next_pc=2 -> dec/exe/wb pulses on successive cycles; pc=2 after 5 cycles; instr_count=1; stat=1.
2. icode=5 (mrmovq), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles; total 9 cycles; wb_en pulses after ack; instr_count=1.
3. Second fetch returns icode=0 -> stat=2, HALT; instr_count=2; busy=0; later start pulses ignored; pc unchanged.
4. imem_ack never arrives, MEM_TIMEOUT=16 -> after 16 req cycles stat=3, imem_req=0, no dec_en ever asserted.
5. step_mode=1, three start pulses over non-memory instructions -> FSM returns to IDLE after each PCUPD; instr_count=3; cycle_count=15.
6. Reset asserted mid-MEMORY with dmem_req high -> next cycle dmem_req=0, pc=RESET_PC, stat=1, counters 0, no wb_en pulse.
